serial_adder_seq: RTL

//  - Bit-serial WIDTH-bit adder: the inverse arithmetic of the half-subtractor family.
//  - Operands are loaded in parallel, one bit pair is added per clock (LSB first) through a

---
 rtl/serial_arith_pkg.sv | 23 ++
 rtl/serial_fa_cell.sv | 21 ++
 rtl/serial_adder_seq.sv | 115 +++++++++++
 3 files changed

// File: rtl/serial_arith_pkg.sv
// Shared definitions for the bit-serial arithmetic engines: FSM encoding,
// default operand width and the counter-width helper.
package serial_arith_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_e;

  localparam int DEF_WIDTH = 8;

  // Bits needed to count 0..value-1; never less than one bit.
  function automatic int clog2(input int value);
    int r;
    r = 1;
    for (int i = 1; i < 31; i++) begin
      if ((1 << i) < value) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/serial_fa_cell.sv
// One-bit full adder composed of two half-adder stages; the single arithmetic
// cell of the bit-serial datapath.
module serial_fa_cell (
  input  logic a_i,
  input  logic b_i,
  input  logic cin_i,
  output logic s_o,
  output logic cout_o
);

  logic ha0_s;
  logic ha0_c;
  logic ha1_c;

  assign ha0_s  = a_i ^ b_i;
  assign ha0_c  = a_i & b_i;
  assign s_o    = ha0_s ^ cin_i;
  assign ha1_c  = ha0_s & cin_i;
  assign cout_o = ha0_c | ha1_c;

endmodule

// File: rtl/serial_adder_seq.sv
// Bit-serial WIDTH-bit adder with start/done handshake, LSB first through a carry flop.
// Optional subtract mode (port 'sub') is enabled by defining SERIAL_ADDSUB_SEL_EN.
module serial_adder_seq
  import serial_arith_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
`ifdef SERIAL_ADDSUB_SEL_EN
  input  logic             sub,
`endif
  output logic [WIDTH-1:0] Sum,
  output logic             Cout,
  output logic             busy,
  output logic             done
);

  localparam int CNT_W = clog2(WIDTH);

  state_e             state_q;
  logic [WIDTH-1:0]   a_q;
  logic [WIDTH-1:0]   b_q;
  logic [WIDTH-1:0]   res_q;
  logic [WIDTH-1:0]   res_d;
  logic [CNT_W-1:0]   cnt_q;
  logic               c_q;
  logic               sub_q;
  logic [WIDTH-1:0]   sum_q;
  logic               cout_q;
  logic               busy_q;
  logic               done_q;
  logic               sub_sel;
  logic               fa_s;
  logic               fa_co;

`ifdef SERIAL_ADDSUB_SEL_EN
  assign sub_sel = sub;
`else
  assign sub_sel = 1'b0;
`endif

  serial_fa_cell u_fa (
    .a_i    (a_q[0]),
    .b_i    (b_q[0]),
    .cin_i  (c_q),
    .s_o    (fa_s),
    .cout_o (fa_co)
  );

  // New sum bit enters at the top so the first (LSB) bit lands at bit 0 after WIDTH shifts.
  assign res_d = {fa_s, res_q[WIDTH-1:1]};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      a_q     <= '0;
      b_q     <= '0;
      res_q   <= '0;
      cnt_q   <= '0;
      c_q     <= 1'b0;
      sub_q   <= 1'b0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        ST_IDLE, ST_DONE: begin
          if (start) begin
            // Subtraction is A + ~B + 1: invert B once here and preset the carry.
            a_q     <= A;
            b_q     <= sub_sel ? ~B : B;
            c_q     <= sub_sel;
            sub_q   <= sub_sel;
            res_q   <= '0;
            cnt_q   <= '0;
            busy_q  <= 1'b1;
            state_q <= ST_SHIFT;
          end else begin
            state_q <= ST_IDLE;
          end
        end
        ST_SHIFT: begin
          a_q   <= a_q >> 1;
          b_q   <= b_q >> 1;
          c_q   <= fa_co;
          res_q <= res_d;
          cnt_q <= cnt_q + CNT_W'(1);
          if (cnt_q == CNT_W'(WIDTH - 1)) begin
            sum_q   <= res_d;
            cout_q  <= sub_q ? ~fa_co : fa_co;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            state_q <= ST_DONE;
          end
        end
        default: begin
          busy_q  <= 1'b0;
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign Sum  = sum_q;
  assign Cout = cout_q;
  assign busy = busy_q;
  assign done = done_q;

endmodule
